regfile_write_demux: RTL and testbench

REGFILE_WRITE_DEMUX -- requirements
Module: regfile_write_demux

---
 rtl/regfile_write_demux_pkg.sv | 11 +
 rtl/regfile_write_demux_lsb_pick16.sv | 19 +
 rtl/regfile_write_demux.sv | 103 ++++++++++
 tb/tb_regfile_write_demux.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_demux_pkg.sv
// Shared definitions for the register-file write demux.
// Covers the FSM encoding and the register-file geometry.
package regfile_write_demux_pkg;
    localparam int NUM_REGS = 16;
    localparam int PC_IDX   = 15;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_write_demux_lsb_pick16.sv
// Lowest-set-bit finder for the burst remaining-list.
// Purely combinational; found=0 means the mask is empty.
module lsb_pick16 (
    input  logic [15:0] mask,
    output logic [3:0]  idx,
    output logic        found
);
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan from the top down so the last hit is the lowest index.
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/regfile_write_demux.sv
// 16-entry register file with one single-write port and an LDM-style burst path.
// A burst fills the registers selected by a mask, lowest index first, one beat at a time.
module regfile_write_demux
    import regfile_write_demux_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [W-1:0]        wr_data,
    input  logic                burst_start,
    input  logic [15:0]         burst_list,
    input  logic                beat_valid,
    input  logic [W-1:0]        beat_data,
    output logic                beat_ready,
    output logic                busy,
    output logic                burst_done,
    output logic [16*W-1:0]     reg_q,
    output logic                pc_wr,
    output logic [W-1:0]        pc_data,
    output logic                dbg_state
);
    state_t       state;
    logic [15:0]  remaining;
    logic [15:0]  rem_next;
    logic [15:0]  we;
    logic [W-1:0] wdata;
    logic [3:0]   pick_idx;
    logic         pick_found;
    logic         accept;
    logic [W-1:0] regs [NUM_REGS];

    // Beat handshake: a beat transfers on any rising edge where beat_valid and
    // beat_ready are both high; the source holds beat_data until that edge.
    assign busy       = (state == BURST);
    assign beat_ready = (state == BURST);
    assign dbg_state  = state;
    assign accept     = busy & beat_valid & pick_found;

    lsb_pick16 u_pick (
        .mask  (remaining),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // One-hot write-enable decode; the two write sources are exclusive by state.
    always_comb begin
        we       = '0;
        wdata    = wr_data;
        rem_next = remaining;
        if (state == IDLE) begin
            if (wr_en) we[wr_addr] = 1'b1;
        end else if (accept) begin
            we[pick_idx]       = 1'b1;
            wdata              = beat_data;
            rem_next[pick_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            burst_done <= 1'b0;
            pc_wr      <= 1'b0;
            pc_data    <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            burst_done <= 1'b0;
            pc_wr      <= we[PC_IDX];
            if (we[PC_IDX]) pc_data <= wdata;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we[i]) regs[i] <= wdata;
            end
            case (state)
                IDLE: begin
                    if (burst_start) begin
                        if (burst_list != '0) begin
                            remaining <= burst_list;
                            state     <= BURST;
                        end else begin
                            burst_done <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    remaining <= rem_next;
                    if (accept && rem_next == '0) begin
                        state      <= IDLE;
                        burst_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign reg_q[W*g +: W] = regs[g];
    end
endmodule

// File: tb/tb_regfile_write_demux.sv
// Directed bench for regfile_write_demux: single writes, gapped bursts, empty burst,
// single/burst collision and reset in the middle of a burst.
module tb_regfile_write_demux;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [3:0]    wr_addr;
    logic [W-1:0]  wr_data;
    logic          burst_start;
    logic [15:0]   burst_list;
    logic          beat_valid;
    logic [W-1:0]  beat_data;
    logic          beat_ready;
    logic          busy;
    logic          burst_done;
    logic [16*W-1:0] reg_q;
    logic          pc_wr;
    logic [W-1:0]  pc_data;
    logic          dbg_state;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp_r [16];

    regfile_write_demux #(.W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .burst_start (burst_start),
        .burst_list  (burst_list),
        .beat_valid  (beat_valid),
        .beat_data   (beat_data),
        .beat_ready  (beat_ready),
        .busy        (busy),
        .burst_done  (burst_done),
        .reg_q       (reg_q),
        .pc_wr       (pc_wr),
        .pc_data     (pc_data),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [16*W-1:0] exp_q();
        logic [16*W-1:0] v;
        for (int i = 0; i < 16; i++) v[W*i +: W] = exp_r[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        burst_start = 1'b0; burst_list = '0;
        beat_valid = 1'b0; beat_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < 16; i++) exp_r[i] = '0;
        step(); step();
        checks++;
        if (reg_q !== exp_q()) $display("FAIL reset_regs got=%h exp=%h", reg_q, exp_q());
        else passes++;
        checks++;
        if ({busy, beat_ready, burst_done, pc_wr, dbg_state} !== 5'b0)
            $display("FAIL reset_ctrl got=%b exp=00000", {busy, beat_ready, burst_done, pc_wr, dbg_state});
        else passes++;
        checks++;
        if (pc_data !== '0) $display("FAIL reset_pc_data got=%h exp=0", pc_data);
        else passes++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_write();
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        exp_r[3] = 32'hDEADBEEF;
        checks++;
        if (reg_q !== exp_q()) $display("FAIL single_r3 got=%h exp=%h", reg_q, exp_q());
        else passes++;
        checks++;
        if (pc_wr !== 1'b0) $display("FAIL single_no_pc got=%b exp=0", pc_wr);
        else passes++;

        wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'hCAFE0001;
        step();
        idle_inputs();
        exp_r[15] = 32'hCAFE0001;
        checks++;
        if ({pc_wr, pc_data} !== {1'b1, 32'hCAFE0001})
            $display("FAIL single_pc got=%b/%h exp=1/cafe0001", pc_wr, pc_data);
        else passes++;
        step();
        checks++;
        if ({pc_wr, pc_data} !== {1'b0, 32'hCAFE0001})
            $display("FAIL pc_hold got=%b/%h exp=0/cafe0001", pc_wr, pc_data);
        else passes++;
        checks++;
        if (reg_q !== exp_q()) $display("FAIL single_r15 got=%h exp=%h", reg_q, exp_q());
        else passes++;
    endtask

    task automatic test_burst_gaps();
        burst_start = 1'b1; burst_list = 16'h8005;
        step();
        idle_inputs();
        checks++;
        if ({busy, beat_ready, dbg_state} !== 3'b111)
            $display("FAIL burst_enter got=%b exp=111", {busy, beat_ready, dbg_state});
        else passes++;

        beat_valid = 1'b1; beat_data = 32'h11;
        step();
        idle_inputs();
        exp_r[0] = 32'h11;
        checks++;
        if (reg_q !== exp_q()) $display("FAIL burst_beat1 got=%h exp=%h", reg_q, exp_q());
        else passes++;
        step(); // stall cycle
        checks++;
        if (reg_q !== exp_q() || busy !== 1'b1) $display("FAIL burst_stall got=%h busy=%b exp=%h busy=1", reg_q, busy, exp_q());
        else passes++;

        beat_valid = 1'b1; beat_data = 32'h22;
        step();
        idle_inputs();
        exp_r[2] = 32'h22;
        checks++;
        if (reg_q !== exp_q() || burst_done !== 1'b0)
            $display("FAIL burst_beat2 got=%h done=%b exp=%h done=0", reg_q, burst_done, exp_q());
        else passes++;
        step();

        beat_valid = 1'b1; beat_data = 32'h33;
        step();
        idle_inputs();
        exp_r[15] = 32'h33;
        checks++;
        if (reg_q !== exp_q()) $display("FAIL burst_beat3 got=%h exp=%h", reg_q, exp_q());
        else passes++;
        checks++;
        if ({burst_done, busy, pc_wr, pc_data} !== {1'b1, 1'b0, 1'b1, 32'h33})
            $display("FAIL burst_end got=%b%b%b/%h exp=101/33", burst_done, busy, pc_wr, pc_data);
        else passes++;
        step();
        checks++;
        if ({burst_done, pc_wr} !== 2'b00) $display("FAIL burst_pulse_width got=%b exp=00", {burst_done, pc_wr});
        else passes++;
    endtask

    task automatic test_empty_burst();
        burst_start = 1'b1; burst_list = 16'h0000;
        step();
        idle_inputs();
        checks++;
        if ({busy, burst_done} !== 2'b01) $display("FAIL empty_burst got=%b exp=01", {busy, burst_done});
        else passes++;
        step();
        checks++;
        if ({busy, burst_done} !== 2'b00) $display("FAIL empty_burst_after got=%b exp=00", {busy, burst_done});
        else passes++;
    endtask

    task automatic test_collision();
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hA5;
        burst_start = 1'b1; burst_list = 16'h0002;
        step();
        idle_inputs();
        exp_r[5] = 32'hA5;
        checks++;
        if (reg_q !== exp_q() || busy !== 1'b1)
            $display("FAIL collide_start got=%h busy=%b exp=%h busy=1", reg_q, busy, exp_q());
        else passes++;

        // Requests raised while busy must be dropped without side effects.
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h66;
        burst_start = 1'b1; burst_list = 16'hFFFF;
        step();
        idle_inputs();
        checks++;
        if (reg_q !== exp_q() || busy !== 1'b1)
            $display("FAIL collide_drop got=%h busy=%b exp=%h busy=1", reg_q, busy, exp_q());
        else passes++;

        beat_valid = 1'b1; beat_data = 32'h77;
        step();
        idle_inputs();
        exp_r[1] = 32'h77;
        checks++;
        if (reg_q !== exp_q() || {busy, burst_done} !== 2'b01)
            $display("FAIL collide_beat got=%h st=%b exp=%h st=01", reg_q, {busy, burst_done}, exp_q());
        else passes++;
        step();
    endtask

    task automatic test_reset_mid_burst();
        burst_start = 1'b1; burst_list = 16'h00F0;
        step();
        idle_inputs();
        beat_valid = 1'b1; beat_data = 32'h44;
        step();
        idle_inputs();
        exp_r[4] = 32'h44;
        checks++;
        if (reg_q !== exp_q() || busy !== 1'b1)
            $display("FAIL mid_beat got=%h busy=%b exp=%h busy=1", reg_q, busy, exp_q());
        else passes++;

        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) exp_r[i] = '0;
        checks++;
        if (reg_q !== exp_q() || {busy, burst_done, pc_wr} !== 3'b000 || pc_data !== '0)
            $display("FAIL mid_reset got=%h st=%b pc=%h exp=%h st=000 pc=0", reg_q, {busy, burst_done, pc_wr}, pc_data, exp_q());
        else passes++;
        step();
        reset = 1'b0;
        step();
        checks++;
        if ({busy, burst_done} !== 2'b00) $display("FAIL post_reset_idle got=%b exp=00", {busy, burst_done});
        else passes++;

        wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h1234;
        step();
        idle_inputs();
        exp_r[7] = 32'h1234;
        checks++;
        if (reg_q !== exp_q()) $display("FAIL post_reset_write got=%h exp=%h", reg_q, exp_q());
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_burst_gaps();
        test_empty_burst();
        test_collision();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
